// File: rtl/dep_issue_scheduler_pkg.sv
// Shared types for the dependency-driven issue scheduler.
// Holds the per-slot state encoding and the slot-index width helper.
package dep_issue_scheduler_pkg;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_WAITING = 2'd1,
    SLOT_ISSUED  = 2'd2
  } slot_state_e;

  localparam int BS_DEFAULT = 16;

  // A single-entry structure would still need a one-bit index.
  function automatic int index_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dep_issue_scheduler_if.sv
// Allocation, issue and completion bundle between the dependency table,
// the scheduler and the execution units.
interface dep_issue_scheduler_if #(parameter int bs = 16);
  import dep_issue_scheduler_pkg::*;

  localparam int bs_bits = index_bits(bs);

  logic               alloc_valid;
  logic [bs_bits-1:0] alloc_index;
  logic [bs-1:0]      alloc_dep;
  logic               alloc_ready;
  logic               issue_valid;
  logic [bs_bits-1:0] issue_index;
  logic               issue_ready;
  logic               complete_valid;
  logic [bs_bits-1:0] complete_index;
  logic [bs_bits:0]   occupancy;
  logic               empty;
  logic               err;

  modport master (
    output alloc_valid, alloc_index, alloc_dep, issue_ready,
           complete_valid, complete_index,
    input  alloc_ready, issue_valid, issue_index, occupancy, empty, err
  );

  modport slave (
    input  alloc_valid, alloc_index, alloc_dep, issue_ready,
           complete_valid, complete_index,
    output alloc_ready, issue_valid, issue_index, occupancy, empty, err
  );

endinterface

// File: rtl/dep_pick_lowest.sv
// Lowest-set-bit priority encoder; index is 0 whenever no request is set.
module dep_pick_lowest
  import dep_issue_scheduler_pkg::*;
#(
  parameter int width = 16,
  localparam int idx_bits = index_bits(width)
) (
  input  logic [width-1:0]    req,
  output logic                valid,
  output logic [idx_bits-1:0] index
);

  // Walking downward lets the lowest set bit win the last assignment.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = width - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = idx_bits'(i);
      end
    end
  end

endmodule

// File: rtl/dep_issue_scheduler.sv
// Per-slot dependency tracking with wake-up on completion and in-order
// (lowest slot first) issue through a valid/ready handshake.
module dep_issue_scheduler
  import dep_issue_scheduler_pkg::*;
#(
  parameter int bs = BS_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  dep_issue_scheduler_if.slave bus
);

  localparam int bs_bits = index_bits(bs);

  slot_state_e      state_q [bs];
  logic [bs-1:0]    dep_q   [bs];
  logic [bs_bits:0] occ_q;
  logic             err_q;

  logic [bs-1:0]      ready_vec;
  logic               pick_valid;
  logic [bs_bits-1:0] pick_index;
  logic               alloc_free;
  logic               alloc_ok;
  logic               complete_ok;
  logic               issue_fire;
  logic [bs-1:0]      complete_mask;
  logic [bs-1:0]      alloc_dep_masked;

  always_comb begin
    for (int i = 0; i < bs; i++) begin
      ready_vec[i] = (state_q[i] == SLOT_WAITING) && (dep_q[i] == '0);
    end
  end

  dep_pick_lowest #(.width(bs)) u_pick (
    .req   (ready_vec),
    .valid (pick_valid),
    .index (pick_index)
  );

  // Accepted alloc, issue and complete always target slots in three different
  // states, so they can never collide on the same slot.
  assign alloc_free    = (state_q[bus.alloc_index] == SLOT_EMPTY);
  assign alloc_ok      = bus.alloc_valid && alloc_free;
  assign complete_ok   = bus.complete_valid && (state_q[bus.complete_index] == SLOT_ISSUED);
  assign issue_fire    = pick_valid && bus.issue_ready;
  assign complete_mask = bs'(1) << bus.complete_index;

  // A same-cycle completion is folded into the new vector, since the column
  // clear below only sees dependencies that were already registered.
  assign alloc_dep_masked = bus.alloc_dep
                          & ~(bs'(1) << bus.alloc_index)
                          & ~(bus.complete_valid ? complete_mask : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < bs; i++) begin
        state_q[i] <= SLOT_EMPTY;
        dep_q[i]   <= '0;
      end
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < bs; i++) begin
        if (alloc_ok && (bus.alloc_index == bs_bits'(i))) begin
          state_q[i] <= SLOT_WAITING;
          dep_q[i]   <= alloc_dep_masked;
        end else if (issue_fire && (pick_index == bs_bits'(i))) begin
          state_q[i] <= SLOT_ISSUED;
        end else if (complete_ok && (bus.complete_index == bs_bits'(i))) begin
          state_q[i] <= SLOT_EMPTY;
          dep_q[i]   <= '0;
        end else if (complete_ok) begin
          dep_q[i] <= dep_q[i] & ~complete_mask;
        end
      end

      case ({alloc_ok, complete_ok})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase

      if ((bus.alloc_valid && !alloc_free) || (bus.complete_valid && !complete_ok)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.alloc_ready = alloc_free;
  assign bus.issue_valid = pick_valid;
  assign bus.issue_index = pick_index;
  assign bus.occupancy   = occ_q;
  assign bus.empty       = (occ_q == '0);
  assign bus.err         = err_q;

endmodule

// File: tb/tb_dep_issue_scheduler.sv
// Directed bench for dep_issue_scheduler: a slot-level reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_dep_issue_scheduler;

  localparam int BS = 16;
  localparam int M_EMPTY   = 0;
  localparam int M_WAITING = 1;
  localparam int M_ISSUED  = 2;

  logic clk = 1'b0;
  logic rst;

  dep_issue_scheduler_if #(.bs(BS)) bus ();

  dep_issue_scheduler #(.bs(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          m_state [BS];
  logic [15:0] m_dep   [BS];
  bit          m_err = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int m_pick();
    for (int i = 0; i < BS; i++) begin
      if (m_state[i] == M_WAITING && m_dep[i] == 16'h0) return i;
    end
    return -1;
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < BS; i++) if (m_state[i] != M_EMPTY) n++;
    return n;
  endfunction

  // Reference model: apply the completion, then the issue, then the allocation.
  always @(posedge clk or posedge rst) begin : model_step
    int p, ai, ci;
    bit a_ok, c_ok;
    if (rst) begin
      for (int i = 0; i < BS; i++) begin
        m_state[i] = M_EMPTY;
        m_dep[i]   = 16'h0;
      end
      m_err = 1'b0;
    end else begin
      p    = m_pick();
      ai   = int'(bus.alloc_index);
      ci   = int'(bus.complete_index);
      a_ok = bus.alloc_valid && (m_state[ai] == M_EMPTY);
      c_ok = bus.complete_valid && (m_state[ci] == M_ISSUED);
      if (bus.alloc_valid && !a_ok) m_err = 1'b1;
      if (bus.complete_valid && !c_ok) m_err = 1'b1;
      if (c_ok) begin
        m_state[ci] = M_EMPTY;
        for (int k = 0; k < BS; k++) m_dep[k][ci] = 1'b0;
      end
      if (p >= 0 && bus.issue_ready) m_state[p] = M_ISSUED;
      if (a_ok) begin
        m_state[ai] = M_WAITING;
        m_dep[ai]   = bus.alloc_dep;
        m_dep[ai][ai] = 1'b0;
        if (bus.complete_valid) m_dep[ai][ci] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    int p;
    p = m_pick();
    checkOutput("cyc_issue_valid", {31'b0, bus.issue_valid}, {31'b0, p >= 0});
    checkOutput("cyc_issue_index", {28'b0, bus.issue_index}, (p < 0) ? 32'd0 : p);
    checkOutput("cyc_occupancy", {27'b0, bus.occupancy}, m_occ());
    checkOutput("cyc_empty", {31'b0, bus.empty}, {31'b0, m_occ() == 0});
    checkOutput("cyc_err", {31'b0, bus.err}, {31'b0, m_err});
    checkOutput("cyc_alloc_ready", {31'b0, bus.alloc_ready},
                {31'b0, m_state[int'(bus.alloc_index)] == M_EMPTY});
  end

  task automatic applyStimulus(input bit av, input int ai, input logic [15:0] ad,
                               input bit ir, input bit cv, input int ci);
    bus.alloc_valid    = av;
    bus.alloc_index    = 4'(ai);
    bus.alloc_dep      = ad;
    bus.issue_ready    = ir;
    bus.complete_valid = cv;
    bus.complete_index = 4'(ci);
    @(posedge clk);
    #1;
    bus.alloc_valid    = 1'b0;
    bus.alloc_index    = '0;
    bus.alloc_dep      = '0;
    bus.issue_ready    = 1'b0;
    bus.complete_valid = 1'b0;
    bus.complete_index = '0;
  endtask

  task automatic alloc(input int ai, input logic [15:0] ad);
    applyStimulus(1'b1, ai, ad, 1'b0, 1'b0, 0);
  endtask

  task automatic issue();
    applyStimulus(1'b0, 0, 16'h0, 1'b1, 1'b0, 0);
  endtask

  task automatic complete(input int ci);
    applyStimulus(1'b0, 0, 16'h0, 1'b0, 1'b1, ci);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 16'h0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.alloc_valid    = 1'b0;
    bus.alloc_index    = '0;
    bus.alloc_dep      = '0;
    bus.issue_ready    = 1'b0;
    bus.complete_valid = 1'b0;
    bus.complete_index = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_issue_valid", {31'b0, bus.issue_valid}, 32'd0);
    checkOutput("rst_occupancy", {27'b0, bus.occupancy}, 32'd0);
    checkOutput("rst_empty", {31'b0, bus.empty}, 32'd1);
    checkOutput("rst_err", {31'b0, bus.err}, 32'd0);
    for (int i = 0; i < BS; i++) begin
      bus.alloc_index = 4'(i);
      #1;
      checkOutput("rst_alloc_ready", {31'b0, bus.alloc_ready}, 32'd1);
    end
    bus.alloc_index = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] single alloc, issue, complete");
    alloc(3, 16'h0000);
    checkOutput("t1_issue_valid", {31'b0, bus.issue_valid}, 32'd1);
    checkOutput("t1_issue_index", {28'b0, bus.issue_index}, 32'd3);
    issue();
    checkOutput("t1_after_issue", {31'b0, bus.issue_valid}, 32'd0);
    checkOutput("t1_occ_issued", {27'b0, bus.occupancy}, 32'd1);
    complete(3);
    checkOutput("t1_occ_done", {27'b0, bus.occupancy}, 32'd0);
    checkOutput("t1_empty", {31'b0, bus.empty}, 32'd1);

    $display("[TB] dependent chain");
    alloc(0, 16'h0000);
    alloc(1, 16'h0001);
    checkOutput("t2_index0", {28'b0, bus.issue_index}, 32'd0);
    issue();
    checkOutput("t2_blocked", {31'b0, bus.issue_valid}, 32'd0);
    complete(0);
    checkOutput("t2_wake_valid", {31'b0, bus.issue_valid}, 32'd1);
    checkOutput("t2_wake_index", {28'b0, bus.issue_index}, 32'd1);
    issue();
    complete(1);

    $display("[TB] self bit and completion bypass");
    alloc(2, 16'h0000);
    issue();
    applyStimulus(1'b1, 5, 16'h0024, 1'b0, 1'b1, 2);
    checkOutput("t3_bypass_valid", {31'b0, bus.issue_valid}, 32'd1);
    checkOutput("t3_bypass_index", {28'b0, bus.issue_index}, 32'd5);
    checkOutput("t3_occ", {27'b0, bus.occupancy}, 32'd1);
    issue();
    complete(5);

    $display("[TB] hold under backpressure");
    alloc(7, 16'h0000);
    alloc(2, 16'h0000);
    repeat (3) begin
      idle();
      checkOutput("t4_hold_index", {28'b0, bus.issue_index}, 32'd2);
    end
    issue();
    checkOutput("t4_next_index", {28'b0, bus.issue_index}, 32'd7);
    issue();
    checkOutput("t4_drained", {31'b0, bus.issue_valid}, 32'd0);
    complete(2);
    complete(7);
    checkOutput("t4_occ", {27'b0, bus.occupancy}, 32'd0);
    checkOutput("t4_err_clean", {31'b0, bus.err}, 32'd0);

    $display("[TB] protocol errors");
    alloc(6, 16'h0001);
    alloc(4, 16'h0001);
    applyStimulus(1'b1, 4, 16'h0000, 1'b0, 1'b1, 6);
    checkOutput("t5_err", {31'b0, bus.err}, 32'd1);
    checkOutput("t5_occ", {27'b0, bus.occupancy}, 32'd2);
    checkOutput("t5_no_issue", {31'b0, bus.issue_valid}, 32'd0);

    $display("[TB] simultaneous issue, complete, alloc");
    alloc(0, 16'h0000);
    issue();
    alloc(10, 16'h0000);
    checkOutput("t6_pre_index", {28'b0, bus.issue_index}, 32'd10);
    applyStimulus(1'b1, 11, 16'h0000, 1'b1, 1'b1, 0);
    checkOutput("t6_index", {28'b0, bus.issue_index}, 32'd4);
    checkOutput("t6_occ", {27'b0, bus.occupancy}, 32'd4);

    rst = 1'b1;
    #2;
    rst = 1'b0;
    checkOutput("t7_err_cleared", {31'b0, bus.err}, 32'd0);

    $display("[TB] fill and asynchronous reset");
    for (int i = 0; i < BS; i++) alloc(i, 16'h0000);
    bus.alloc_index = 4'd5;
    #1;
    checkOutput("t7_full_occ", {27'b0, bus.occupancy}, 32'd16);
    checkOutput("t7_full_ready", {31'b0, bus.alloc_ready}, 32'd0);
    checkOutput("t7_full_index", {28'b0, bus.issue_index}, 32'd0);
    bus.alloc_valid = 1'b1;
    rst = 1'b1;
    #2;
    checkOutput("t7_rst_occ", {27'b0, bus.occupancy}, 32'd0);
    checkOutput("t7_rst_empty", {31'b0, bus.empty}, 32'd1);
    checkOutput("t7_rst_valid", {31'b0, bus.issue_valid}, 32'd0);
    checkOutput("t7_rst_ready", {31'b0, bus.alloc_ready}, 32'd1);
    checkOutput("t7_rst_err", {31'b0, bus.err}, 32'd0);
    bus.alloc_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dep_issue_scheduler.md
# dep_issue_scheduler

Consumes the per-instruction dependency vector (idt) produced by the instruction register table and decides when each buffered instruction may issue. Holds one dependency vector per instruction-buffer slot, wakes slots as producers complete, and issues the lowest-index ready slot through a valid/ready handshake. It sits between the dependency table (allocation side) and the execution units (issue/complete side).

## Interface
- bs, 16, number of instruction-buffer slots; power of two, ≥2
- bs_bits, $clog2(bs), local, slot index width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- alloc_valid  in  1  new instruction written into slot alloc_index this cycle
- alloc_index  in  bs_bits  target slot
- alloc_dep  in  bs  dependency vector (idt) of the new instruction; bit k = depends on slot k
- alloc_ready  out  1  slot alloc_index is EMPTY (combinational from registered state)
- issue_valid  out  1  a slot is ready to issue
- issue_index  out  bs_bits  lowest-index ready slot; 0 when issue_valid=0
- issue_ready  in  1  execution side accepts issue_index
- complete_valid  in  1  slot complete_index finished execution
- complete_index  in  bs_bits  completing slot
- occupancy  out  bs_bits+1  number of non-EMPTY slots
- empty  out  1  occupancy == 0
- err  out  1  sticky protocol-error flag

## Operation
- Per slot: state ∈ {EMPTY, WAITING, ISSUED}, dep[bs-1:0].
- Alloc accepted when alloc_valid && slot EMPTY: state←WAITING, dep←alloc_dep with bit alloc_index forced 0, and with bit complete_index forced 0 if complete_valid same cycle (completion bypass).
- Alloc to non-EMPTY slot: ignored, err←1.
- Ready(slot) = state==WAITING && dep==0. issue_index = lowest ready index.
- Issue handshake: issue_valid && issue_ready at edge → that slot ISSUED. issue_valid/issue_index stable until accepted unless a lower-index slot becomes ready (re-selection allowed; no handshake fires without ready).
- Complete accepted when complete_valid && slot ISSUED: state←EMPTY, dep←0, and bit complete_index cleared in every slot's dep.
- Complete on EMPTY or WAITING slot: ignored (no column clear), err←1.
- occupancy +1 on accepted alloc, −1 on accepted complete; both same cycle → unchanged. Never exceeds bs.
- err cleared only by rst.

## Timing
- Reset: all slots EMPTY, dep 0, issue_valid 0, issue_index 0, occupancy 0, empty 1, err 0, alloc_ready 1 for any index. Reset mid-operation discards all slots immediately.
- Issue outputs are combinational from registered slot state only; no input→issue_valid path.
- Alloc with dep=0 at edge N → issue_valid in cycle N+1 (1-cycle latency).
- Complete at edge N → dependents with no other bits set visible as ready in cycle N+1.
- Same-cycle alloc X + complete X: alloc rejected (X not EMPTY at edge), err←1; complete applies.
- Same-cycle issue of A + complete of B + alloc of C (distinct): all three apply.
- Full (occupancy==bs): alloc_ready 0 for every index.

## Structure
- Shared package: slot-state enum (EMPTY/WAITING/ISSUED), bs_bits derivation helper.
- One sub-module: dep_pick_lowest — combinational lowest-set-bit priority encoder (bs-wide request → valid + index); reused for any future free-slot picker.

## Test plan
- Reset then alloc slot 3, dep 0 → issue_valid=1, issue_index=3 next cycle; issue_ready=1 → slot 3 ISSUED, issue_valid=0; complete 3 → occupancy 0, empty=1.
- Alloc slot 0 dep 0, slot 1 dep 16'h0001 → only 0 issues; complete 0 → cycle after, issue_index=1.
- Alloc slot 5 dep 16'h0024 (slots 2,5) → self bit dropped, waits only on 2; slots 2 ISSUED then completed at same edge as slot 5 alloc (bypass) → slot 5 ready next cycle.
- Slots 2 and 7 ready, issue_ready=0 for 3 cycles → issue_index held at 2, no state change; then accept → issue_index=7.
- Alloc to WAITING slot 4, complete on WAITING slot 6 → both ignored, err=1, occupancy unchanged.
- Fill all 16 slots → occupancy 16, alloc_ready 0; assert rst mid-stream → all outputs at reset values asynchronously.
